// File: rtl/mem_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_pkg : shared widths, default latency and pipeline stage record
// Revision: 1.0
// ----------------------------------------------------------------------------
package mem_pkg;

  localparam int MEM_DATA_W          = 16;
  localparam int MEM_ADDR_W          = 16;
  localparam int MEM_LATENCY_DEFAULT = 4;

  typedef struct packed {
    logic                  valid;
    logic [MEM_DATA_W-1:0] data;
  } mem_stage_t;

endpackage
`default_nettype wire

// File: rtl/mem_word_array.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_word_array : 2^DEPTH_LOG2 x 16 backing store, sync write, comb read
// Revision: 1.0
// ----------------------------------------------------------------------------
module mem_word_array
  import mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 15
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] word_idx,
  input  logic [MEM_DATA_W-1:0] wr_data,
  output logic [MEM_DATA_W-1:0] rd_data
);

  logic [MEM_DATA_W-1:0] r_mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[word_idx] <= wr_data;
    end
  end

  assign rd_data = r_mem[word_idx];

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_responder : fixed-latency pipelined memory model, in-order read returns
// Revision: 1.0
// ----------------------------------------------------------------------------
module mem_responder
  import mem_pkg::*;
#(
  parameter int LATENCY    = MEM_LATENCY_DEFAULT,
  parameter int DEPTH_LOG2 = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  wr,
  input  logic [MEM_ADDR_W-1:0] addr,
  input  logic [MEM_DATA_W-1:0] data_in,
  output logic [MEM_DATA_W-1:0] data_out,
  output logic                  data_valid,
  output logic                  busy
);

  mem_stage_t            r_pipe [LATENCY];
  logic                  w_rd;
  logic                  w_wr_en;
  logic [MEM_DATA_W-1:0] w_rd_data;
  logic                  w_busy;
  logic [MEM_ADDR_W-1:0] w_unused_addr;

  assign w_rd          = enable & ~wr;
  // Writes must not land while reset is held, even though the array has no reset.
  assign w_wr_en       = enable & wr & rst;
  assign w_unused_addr = addr;

  mem_word_array #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk      (clk),
    .wr_en    (w_wr_en),
    .word_idx (addr[DEPTH_LOG2:1]),
    .wr_data  (data_in),
    .rd_data  (w_rd_data)
  );

  // Read data is captured at issue, so later writes cannot disturb in-flight words.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < LATENCY; k++) begin
        r_pipe[k] <= '0;
      end
    end else begin
      r_pipe[0].valid <= w_rd;
      r_pipe[0].data  <= w_rd ? w_rd_data : '0;
      for (int k = 1; k < LATENCY; k++) begin
        r_pipe[k] <= r_pipe[k-1];
      end
    end
  end

  always_comb begin
    w_busy = 1'b0;
    for (int k = 0; k < LATENCY; k++) begin
      w_busy = w_busy | r_pipe[k].valid;
    end
  end

  assign data_valid = r_pipe[LATENCY-1].valid;
  assign data_out   = r_pipe[LATENCY-1].valid ? r_pipe[LATENCY-1].data : '0;
  assign busy       = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mem_responder : directed bench for mem_responder (LATENCY 4 and 1 builds)
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        wr;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        data_valid;
  logic        busy;
  logic [15:0] data_out1;
  logic        data_valid1;
  logic        busy1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_responder #(.LATENCY(4), .DEPTH_LOG2(15)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .wr         (wr),
    .addr       (addr),
    .data_in    (data_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy)
  );

  mem_responder #(.LATENCY(1), .DEPTH_LOG2(8)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .wr         (wr),
    .addr       (addr),
    .data_in    (data_in),
    .data_out   (data_out1),
    .data_valid (data_valid1),
    .busy       (busy1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic en, input logic w, input logic [15:0] a, input logic [15:0] d);
    enable  = en;
    wr      = w;
    addr    = a;
    data_in = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [15:0] a, input logic [15:0] d);
    drive(1'b1, 1'b1, a, d);
    tick();
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic drain();
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    repeat (6) tick();
  endtask

  initial begin
    logic [15:0] a;
    logic [15:0] exp_d;
    logic        exp_v;

    rst = 1'b1;
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    #2 rst = 1'b0;
    #1;
    check("reset dv",    data_valid,  1'b0);
    check("reset data",  data_out,    16'h0000);
    check("reset busy",  busy,        1'b0);
    check("reset dv1",   data_valid1, 1'b0);
    check("reset busy1", busy1,       1'b0);
    tick();
    tick();
    #2 rst = 1'b1;
    tick();

    // single read latency
    write_word(16'h0020, 16'hBEEF);
    drain();
    for (int c = 0; c <= 12; c++) begin
      drive(c == 5, 1'b0, 16'h0020, 16'h0000);
      check($sformatf("t1 dv c%0d", c),   data_valid, c == 9);
      check($sformatf("t1 data c%0d", c), data_out,   (c == 9) ? 16'hBEEF : 16'h0000);
      check($sformatf("t1 busy c%0d", c), busy,       c >= 6 && c <= 9);
      tick();
    end

    // 8-beat burst
    for (int i = 0; i < 8; i++) begin
      a     = 16'h1230 + 16'(2 * i);
      exp_d = 16'hA000 + 16'(i);
      write_word(a, exp_d);
    end
    drain();
    for (int c = 0; c <= 13; c++) begin
      a = 16'h1230 + 16'(2 * c);
      drive(c < 8, 1'b0, a, 16'h0000);
      exp_v = (c >= 4 && c <= 11);
      exp_d = exp_v ? 16'hA000 + 16'(c - 4) : 16'h0000;
      check($sformatf("t2 dv c%0d", c),   data_valid, exp_v);
      check($sformatf("t2 data c%0d", c), data_out,   exp_d);
      tick();
    end
    drain();

    // write then read, odd address aliases same word
    for (int c = 0; c <= 8; c++) begin
      if (c == 0)      drive(1'b1, 1'b1, 16'h0040, 16'h1234);
      else if (c == 1) drive(1'b1, 1'b0, 16'h0040, 16'h0000);
      else if (c == 2) drive(1'b1, 1'b0, 16'h0041, 16'h0000);
      else             drive(1'b0, 1'b0, 16'h0000, 16'h0000);
      exp_v = (c == 5 || c == 6);
      check($sformatf("t3 dv c%0d", c),   data_valid, exp_v);
      check($sformatf("t3 data c%0d", c), data_out,   exp_v ? 16'h1234 : 16'h0000);
      check($sformatf("t3 busy c%0d", c), busy,       c >= 2 && c <= 6);
      tick();
    end
    drain();

    // snapshot: write between two reads of the same word
    write_word(16'h0100, 16'h0001);
    drain();
    for (int c = 0; c <= 8; c++) begin
      if (c == 0)      drive(1'b1, 1'b0, 16'h0100, 16'h0000);
      else if (c == 1) drive(1'b1, 1'b1, 16'h0100, 16'h0002);
      else if (c == 2) drive(1'b1, 1'b0, 16'h0100, 16'h0000);
      else             drive(1'b0, 1'b0, 16'h0000, 16'h0000);
      exp_d = (c == 4) ? 16'h0001 : (c == 6) ? 16'h0002 : 16'h0000;
      check($sformatf("t4 dv c%0d", c),   data_valid, c == 4 || c == 6);
      check($sformatf("t4 data c%0d", c), data_out,   exp_d);
      tick();
    end
    drain();

    // reset mid-burst; a write during reset must be dropped
    for (int c = 0; c <= 6; c++) begin
      a = 16'h1230 + 16'(2 * c);
      drive(1'b1, 1'b0, a, 16'h0000);
      exp_v = (c >= 4);
      check($sformatf("t5 dv c%0d", c),   data_valid, exp_v);
      check($sformatf("t5 data c%0d", c), data_out,   exp_v ? 16'hA000 + 16'(c - 4) : 16'h0000);
      if (c == 6) begin
        #2 rst = 1'b0;
        #1;
        check("t5 async dv",   data_valid, 1'b0);
        check("t5 async data", data_out,   16'h0000);
        check("t5 async busy", busy,       1'b0);
      end
      tick();
    end
    drive(1'b1, 1'b1, 16'h0040, 16'hFFFF);
    tick();
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    #2 rst = 1'b1;
    tick();
    for (int c = 9; c <= 20; c++) begin
      drive(c == 15, 1'b0, 16'h0040, 16'h0000);
      check($sformatf("t5 dv c%0d", c),   data_valid, c == 19);
      check($sformatf("t5 data c%0d", c), data_out,   (c == 19) ? 16'h1234 : 16'h0000);
      check($sformatf("t5 busy c%0d", c), busy,       c >= 16 && c <= 19);
      tick();
    end
    drain();

    // LATENCY=1 build alongside the default build
    write_word(16'h0060, 16'h5555);
    write_word(16'h0062, 16'h6666);
    drain();
    for (int c = 0; c <= 10; c++) begin
      if (c == 3 || c == 5) drive(1'b1, 1'b0, 16'h0060, 16'h0000);
      else if (c == 4)      drive(1'b1, 1'b0, 16'h0062, 16'h0000);
      else                  drive(1'b0, 1'b0, 16'h0000, 16'h0000);
      exp_v = (c >= 4 && c <= 6);
      exp_d = (c == 5) ? 16'h6666 : exp_v ? 16'h5555 : 16'h0000;
      check($sformatf("t6 dv1 c%0d", c),   data_valid1, exp_v);
      check($sformatf("t6 data1 c%0d", c), data_out1,   exp_d);
      check($sformatf("t6 busy1 c%0d", c), busy1,       exp_v);
      check($sformatf("t6 dv c%0d", c),    data_valid,  c >= 7 && c <= 9);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
